// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB3 completer with register bank, RO write counter, wait states
module apb_slave_regfile #(
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Index of the read-only write counter, and the register count widened
    // by one bit so NUM_REGS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W-1:0] WCOUNT_IDX = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);
    localparam logic [3:0]        WAIT_INIT  = 4'(WAIT_STATES);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wcnt;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       regs [0:NUM_REGS-2];
    logic [31:0]       wcount;
    logic              setup_err;
    logic [31:0]       rd_mux;
    logic              enter_access;
    logic              do_write;

    assign pready       = (state == ACCESS) && (wcnt == 4'd0);
    assign pslverr      = pready && err_q;
    assign enter_access = (state == SETUP) && psel && penable;
    assign do_write     = pready && wr_q && !err_q;

    // Next-state decode; a completed ACCESS re-evaluates the bus like IDLE does.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (psel && !penable) state_nxt = SETUP;
            end
            SETUP: begin
                if (!psel)        state_nxt = IDLE;
                else if (penable) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (pready)                  state_nxt = (psel && !penable) ? SETUP : IDLE;
                else if (!psel || !penable)  state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Error decode and read mux from the live bus address during SETUP.
    always_comb begin
        setup_err = ({1'b0, paddr} >= NUM_REGS_W) || (pwrite && (paddr == WCOUNT_IDX));
        rd_mux    = 32'd0;
        if (paddr == WCOUNT_IDX) rd_mux = wcount;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (paddr == ADDR_W'(i)) rd_mux = regs[i];
        end
    end

    // FSM state, wait counter, and capture of the transfer at SETUP->ACCESS.
    always_ff @(posedge pclk) begin
        if (prst) begin
            state   <= IDLE;
            wcnt    <= 4'd0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            prdata  <= 32'd0;
        end else begin
            state <= state_nxt;
            if (enter_access) begin
                wcnt    <= WAIT_INIT;
                addr_q  <= paddr;
                wr_q    <= pwrite;
                wdata_q <= pwdata;
                err_q   <= setup_err;
                if (!pwrite) prdata <= setup_err ? 32'd0 : rd_mux;
            end else if ((state == ACCESS) && (wcnt != 4'd0)) begin
                wcnt <= wcnt - 4'd1;
            end
        end
    end

    // Register bank and write counter; writes land only on a clean completion.
    always_ff @(posedge pclk) begin
        if (prst) begin
            for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= 32'd0;
            wcount <= 32'd0;
        end else if (do_write) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                if (addr_q == ADDR_W'(i)) regs[i] <= wdata_q;
            end
            wcount <= wcount + 32'd1;
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - directed scoreboard bench for apb_slave_regfile
module tb_apb_slave_regfile;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        wr;
        int          waits;
    } exp_t;

    logic        pclk;
    logic        prst;
    logic        psel0, psel1;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1;
    logic        pslverr0, pslverr1;

    int          sel;
    logic        rdy;
    logic        serr;
    logic [31:0] rdat;

    exp_t        sb[$];
    logic [31:0] mdl [2][8];
    int          n_cmp;
    int          n_bad;

    apb_slave_regfile #(.ADDR_W(4), .NUM_REGS(8), .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .prst(prst), .psel(psel0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_regfile #(.ADDR_W(4), .NUM_REGS(8), .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .prst(prst), .psel(psel1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always_comb begin
        rdy  = (sel == 0) ? pready0  : pready1;
        serr = (sel == 0) ? pslverr0 : pslverr1;
        rdat = (sel == 0) ? prdata0  : prdata1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 8; j++) mdl[i][j] = 32'd0;
    endtask

    task automatic idle(input int n);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        repeat (n) begin @(posedge pclk); #1; end
    endtask

    task automatic xfer(input int inst, input logic wr, input logic [3:0] a,
                        input logic [31:0] d, input logic chg);
        exp_t e;
        int   lows;
        e.wr    = wr;
        e.waits = (inst == 0) ? 0 : 3;
        e.err   = (a >= 4'd8) || (wr && (a == 4'd7));
        e.rdata = (!wr && (a < 4'd8)) ? mdl[inst][a[2:0]] : 32'd0;
        if (wr && !e.err) begin
            mdl[inst][a[2:0]] = d;
            mdl[inst][7]      = mdl[inst][7] + 32'd1;
        end
        sb.push_back(e);
        sel = inst;
        psel0 = (inst == 0); psel1 = (inst == 1);
        penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        check("pready_in_setup", 32'(rdy), 32'd0);
        lows = 0;
        do begin
            @(posedge pclk); #1;
            if (chg) begin paddr = 4'd4; pwdata = 32'hFFFF_FFFF; end
            if (!rdy) lows++;
        end while (!rdy && lows < 50);
        e = sb.pop_front();
        check("pready_done", 32'(rdy), 32'd1);
        check("wait_cycles", 32'(lows), 32'(e.waits));
        check("pslverr", 32'(serr), 32'(e.err));
        if (!e.wr) check("prdata", rdat, e.rdata);
        psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; sel = 0;
        prst = 1'b1; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
        pwrite = 1'b0; paddr = 4'd0; pwdata = 32'd0;
        clear_model();

        // 1: reset state and read-back of zeroed bank
        repeat (2) @(posedge pclk);
        #1;
        check("rst_prdata0", prdata0, 32'd0);
        check("rst_pready0", 32'(pready0), 32'd0);
        check("rst_pslverr0", 32'(pslverr0), 32'd0);
        check("rst_prdata1", prdata1, 32'd0);
        check("rst_pready1", 32'(pready1), 32'd0);
        prst = 1'b0;
        idle(1);
        for (int i = 0; i < 7; i++) xfer(0, 1'b0, 4'(i), 32'd0, 1'b0);

        // 2: zero-wait back-to-back writes, read-back, write counter
        for (int i = 0; i < 3; i++) xfer(0, 1'b1, 4'(i), 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) xfer(0, 1'b0, 4'(i), 32'd0, 1'b0);
        xfer(0, 1'b0, 4'd7, 32'd0, 1'b0);

        // 3: three wait states
        xfer(1, 1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0);
        xfer(1, 1'b0, 4'd5, 32'd0, 1'b0);

        // 4: out-of-range and read-only errors
        xfer(0, 1'b1, 4'd9, 32'h55, 1'b0);
        xfer(0, 1'b0, 4'd9, 32'd0, 1'b0);
        xfer(0, 1'b1, 4'd7, 32'h1234, 1'b0);
        xfer(0, 1'b0, 4'd7, 32'd0, 1'b0);
        idle(1);
        check("idle_pslverr0", 32'(pslverr0), 32'd0);
        check("hold_prdata0", prdata0, 32'd3);

        // 6: bus changes during ACCESS are ignored
        xfer(1, 1'b1, 4'd2, 32'h11, 1'b1);
        for (int i = 0; i < 8; i++) xfer(1, 1'b0, 4'(i), 32'd0, 1'b0);

        // 5a: abort by dropping psel mid-wait
        sel = 1;
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd1; pwdata = 32'hAA;
        @(posedge pclk); #1;
        penable = 1'b1;
        repeat (2) begin
            @(posedge pclk); #1;
            check("abort_wait_pready", 32'(pready1), 32'd0);
        end
        idle(2);
        check("abort_idle_pready", 32'(pready1), 32'd0);
        xfer(1, 1'b0, 4'd1, 32'd0, 1'b0);
        xfer(1, 1'b0, 4'd7, 32'd0, 1'b0);

        // 5b: reset during ACCESS
        psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd3; pwdata = 32'h77;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        prst = 1'b1;
        @(posedge pclk); #1;
        check("midrst_pready1", 32'(pready1), 32'd0);
        check("midrst_prdata1", prdata1, 32'd0);
        prst = 1'b0;
        clear_model();
        idle(2);
        for (int i = 0; i < 8; i++) xfer(1, 1'b0, 4'(i), 32'd0, 1'b0);
        for (int i = 0; i < 8; i++) xfer(0, 1'b0, 4'(i), 32'd0, 1'b0);
        idle(2);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
